memcard_ctrl: RTL
=================

Name: memcard_ctrl

Overview:
Host-side initiator for the 8-bit memory card slot. It turns single-cycle CPU-side read/write requests into card bus cycles (CDA, CDD, nCE, nOE, nWE, nREG) with programmable setup, access and hold timing. It also synchronises the card-detect and write-protect lines and rejects illegal accesses. It sits between the system address decoder and the card connector.

Parameters:
SETUP_CYC, 1, cycles nCE is low before the strobe falls (minimum 1)
ACCESS_CYC, 3, cycles nOE/nWE is low; 3 x 41.67 ns covers a 100 ns card
HOLD_CYC, 1, cycles nCE, CDA and write data stay valid after the strobe rises (minimum 1)

Ports:
CLK_24M  in  1  system clock
nRESET  in  1  asynchronous active-low reset
REQ  in  1  one-cycle request pulse; sampled only in IDLE
RW  in  1  1 = read, 0 = write; sampled with REQ
REG_SEL  in  1  1 = attribute space (drives nREG low)
ADDR  in  24  card address; sampled with REQ
WDATA  in  8  write data; sampled with REQ
RDATA  out  8  read data; valid from ACK onward until the next ACK
ACK  out  1  one-cycle completion pulse
ERR  out  1  valid with ACK; 1 = access rejected or aborted
BUSY  out  1  high from the cycle after REQ is accepted through the ACK cycle
PRESENT  out  1  synchronised card present (nCD1 and nCD2 both low)
PROTECTED  out  1  synchronised write protect (nWP low)
CDA  out  24  card address bus
CDD_OUT  out  8  write data to card
CDD_OE  out  1  drive enable for CDD[7:0]
CDD_IN  in  8  read data from card
nCE, nOE, nWE, nREG  out  1 each  card strobes, active low
nCD1, nCD2, nWP  in  1 each  card status lines (asynchronous)

Behaviour:
- Reset (asynchronous) forces:
  - nCE, nOE, nWE, nREG = 1; CDD_OE = 0; CDA = 0; CDD_OUT = 0; RDATA = 0.
  - ACK, ERR, BUSY = 0; PRESENT, PROTECTED = 0; synchroniser flops cleared to the "absent/unprotected" value.
  - State machine to IDLE.
  - Strobes release in the same instant the reset asserts, including mid-cycle.
- nCD1, nCD2 and nWP each pass through a 2-flop synchroniser before use.
- State machine: IDLE -> SETUP -> ACCESS -> HOLD -> DONE -> IDLE. A separate IDLE -> DONE path handles rejects.
- IDLE:
  - All strobes high, CDD_OE = 0.
  - When REQ = 1: latch RW, REG_SEL, ADDR and WDATA.
  - If PRESENT = 0, or (RW = 0 and PROTECTED = 1): go to DONE with the error flag set; no strobe ever falls.
  - Otherwise go to SETUP.
- SETUP (SETUP_CYC cycles):
  - CDA = latched address; nCE = 0; nREG = !REG_SEL.
  - For writes: CDD_OE = 1, CDD_OUT = WDATA.
- ACCESS (ACCESS_CYC cycles):
  - Read: nOE = 0. RDATA captures CDD_IN on the clock edge that ends the last ACCESS cycle.
  - Write: nWE = 0.
- HOLD (HOLD_CYC cycles): strobe high; nCE, nREG, CDA, CDD_OE and CDD_OUT unchanged.
- DONE (1 cycle):
  - nCE = 1, nREG = 1, CDD_OE = 0.
  - ACK = 1, ERR = error flag.
  - Next state is IDLE.
- Latency with defaults: REQ accepted on edge 0 gives SETUP in cycle 1, ACCESS in cycles 2-4, HOLD in cycle 5 and ACK in cycle 6. In general, ACK arrives SETUP_CYC + ACCESS_CYC + HOLD_CYC + 1 cycles after acceptance; a reject ACKs 1 cycle after acceptance.
- nOE and nWE are never low in the same cycle. Neither strobe is ever low while nCE = 1.
- REQ while BUSY is ignored: no queueing, no effect on the current cycle.
- Card removal (PRESENT falls) during SETUP or ACCESS:
  - The strobe rises in the next cycle; continue through HOLD, then DONE with ERR = 1.
  - For an aborted read, RDATA keeps its previous value.
- PROTECTED changing mid-write has no effect; it is only checked at acceptance.
- CDA holds its last value in IDLE; bus glitches are avoided.

Test Plan:
1. Card present, unprotected: write ADDR=0x000123, WDATA=0xA5 -> nCE low cycles 1-5, nWE low exactly cycles 2-4, CDD_OE=1 cycles 1-5, CDD_OUT=0xA5; ACK=1, ERR=0 in cycle 6.
2. Read 0x000123 against a card model with 100 ns access returning 0xA5 -> nOE low cycles 2-4, CDD_OE=0 throughout; RDATA=0xA5 at ACK in cycle 6.
3. nCD1=nCD2=1 (absent), REQ read -> no strobe ever falls; ACK=1, ERR=1 one cycle after acceptance; RDATA unchanged.
4. nWP=0, REQ write 0x5A -> rejected: ACK with ERR=1, nWE stays 1. The following read to the same address succeeds with ERR=0.
5. REQ pulses at cycles 2 and 4 during a busy read -> ignored: exactly one ACK; nOE/nWE never both low. Run again with REG_SEL=1 and check nREG=0 for the whole nCE window.
6. Async nRESET low during ACCESS of a write -> nWE, nCE high and CDD_OE=0 immediately; after release, BUSY=0, state IDLE; PRESENT re-rises 2 cycles after reset release with the card inserted.

Source files
------------

// File: rtl/memcard_if.sv
// CPU-side request/response bus of the memory card controller.
// The requester (address decoder / CPU) uses the master modport,
// the card controller uses the slave modport.
interface memcard_if;
   logic        REQ;
   logic        RW;
   logic        REG_SEL;
   logic [23:0] ADDR;
   logic [7:0]  WDATA;
   logic [7:0]  RDATA;
   logic        ACK;
   logic        ERR;
   logic        BUSY;

   modport master (
      output REQ, RW, REG_SEL, ADDR, WDATA,
      input  RDATA, ACK, ERR, BUSY
   );

   modport slave (
      input  REQ, RW, REG_SEL, ADDR, WDATA,
      output RDATA, ACK, ERR, BUSY
   );
endinterface

// File: rtl/memcard_ctrl.sv
// Host-side initiator for the 8-bit memory card slot.
// Converts single-cycle CPU requests into timed card bus cycles
// (SETUP -> ACCESS -> HOLD -> DONE), synchronises card-detect and
// write-protect, and rejects or aborts illegal accesses.
// All card-side outputs are registered from the next-state decode so the
// connector never sees combinational glitches, and the asynchronous reset
// releases every strobe immediately.
module memcard_ctrl #(
   parameter int SETUP_CYC  = 1,
   parameter int ACCESS_CYC = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic        CLK_24M,
   input  logic        nRESET,
   memcard_if.slave    bus,
   output logic        PRESENT,
   output logic        PROTECTED,
   output logic [23:0] CDA,
   output logic [7:0]  CDD_OUT,
   output logic        CDD_OE,
   input  logic [7:0]  CDD_IN,
   output logic        nCE,
   output logic        nOE,
   output logic        nWE,
   output logic        nREG,
   input  logic        nCD1,
   input  logic        nCD2,
   input  logic        nWP
);

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ACCESS = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_err, w_err_nxt;

   logic               r_cd1_s1, r_cd1_s2, r_cd2_s1, r_cd2_s2, r_wp_s1, r_wp_s2;
   logic               w_present, w_protected;

   logic               r_rw, r_reg_sel;
   logic [23:0]        r_addr;
   logic [7:0]         r_wdata;

   logic               w_take;
   logic               w_rw, w_reg_sel;
   logic [23:0]        w_addr;
   logic [7:0]         w_wdata;

   logic               w_win;
   logic               w_nce_nxt, w_noe_nxt, w_nwe_nxt, w_nreg_nxt, w_cdd_oe_nxt;
   logic [23:0]        w_cda_nxt;
   logic [7:0]         w_cdd_out_nxt;
   logic               w_ack_nxt, w_errout_nxt, w_busy_nxt;
   logic               w_capture;

   assign w_present   = ~(r_cd1_s2 | r_cd2_s2);
   assign w_protected = ~r_wp_s2;
   assign PRESENT     = w_present;
   assign PROTECTED   = w_protected;

   // Request fields are taken straight from the bus on the accepting edge,
   // otherwise from the latched copy, so the first bus cycle is already correct.
   assign w_take    = (r_state == S_IDLE) && bus.REQ;
   assign w_rw      = w_take ? bus.RW      : r_rw;
   assign w_reg_sel = w_take ? bus.REG_SEL : r_reg_sel;
   assign w_addr    = w_take ? bus.ADDR    : r_addr;
   assign w_wdata   = w_take ? bus.WDATA   : r_wdata;

   // Read data is sampled on the edge that ends the last ACCESS cycle, unless the card just vanished.
   assign w_capture = (r_state == S_ACCESS) && (r_cnt == '0) && r_rw && w_present;

   // Two-flop synchronisers; reset value means "card absent, not protected".
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         r_cd1_s1 <= 1'b1;
         r_cd1_s2 <= 1'b1;
         r_cd2_s1 <= 1'b1;
         r_cd2_s2 <= 1'b1;
         r_wp_s1  <= 1'b1;
         r_wp_s2  <= 1'b1;
      end else begin
         r_cd1_s1 <= nCD1;
         r_cd1_s2 <= r_cd1_s1;
         r_cd2_s1 <= nCD2;
         r_cd2_s2 <= r_cd2_s1;
         r_wp_s1  <= nWP;
         r_wp_s2  <= r_wp_s1;
      end
   end

   // Latch the request fields when a request is accepted in IDLE.
   always_ff @(posedge CLK_24M) begin
      if (w_take) begin
         r_rw      <= bus.RW;
         r_reg_sel <= bus.REG_SEL;
         r_addr    <= bus.ADDR;
         r_wdata   <= bus.WDATA;
      end
   end

   // State register with phase counter and sticky error flag.
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state logic: phase sequencing, reject at acceptance, abort on card removal.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE: begin
            if (bus.REQ) begin
               if (!w_present || (!bus.RW && w_protected)) begin
                  w_state_nxt = S_DONE;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_SETUP;
                  w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                  w_err_nxt   = 1'b0;
               end
            end
         end
         S_SETUP: begin
            if (!w_present) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
               w_err_nxt   = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_ACCESS;
               w_cnt_nxt   = CNT_W'(ACCESS_CYC - 1);
            end
         end
         S_ACCESS: begin
            if (!w_present) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
               w_err_nxt   = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode for the coming cycle; strobes only inside the nCE window.
   always_comb begin
      w_win         = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS) ||
                      (w_state_nxt == S_HOLD);
      w_nce_nxt     = ~w_win;
      w_nreg_nxt    = w_win ? ~w_reg_sel : 1'b1;
      w_noe_nxt     = ~((w_state_nxt == S_ACCESS) && w_rw);
      w_nwe_nxt     = ~((w_state_nxt == S_ACCESS) && !w_rw);
      w_cdd_oe_nxt  = w_win && !w_rw;
      w_cdd_out_nxt = (w_win && !w_rw) ? w_wdata : CDD_OUT;
      w_cda_nxt     = w_win ? w_addr : CDA;
      w_ack_nxt     = (w_state_nxt == S_DONE);
      w_errout_nxt  = (w_state_nxt == S_DONE) && w_err_nxt;
      w_busy_nxt    = (w_state_nxt != S_IDLE);
   end

   // Registered card strobes, buses and CPU handshake outputs.
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         nCE      <= 1'b1;
         nOE      <= 1'b1;
         nWE      <= 1'b1;
         nREG     <= 1'b1;
         CDD_OE   <= 1'b0;
         CDD_OUT  <= '0;
         CDA      <= '0;
         bus.ACK  <= 1'b0;
         bus.ERR  <= 1'b0;
         bus.BUSY <= 1'b0;
      end else begin
         nCE      <= w_nce_nxt;
         nOE      <= w_noe_nxt;
         nWE      <= w_nwe_nxt;
         nREG     <= w_nreg_nxt;
         CDD_OE   <= w_cdd_oe_nxt;
         CDD_OUT  <= w_cdd_out_nxt;
         CDA      <= w_cda_nxt;
         bus.ACK  <= w_ack_nxt;
         bus.ERR  <= w_errout_nxt;
         bus.BUSY <= w_busy_nxt;
      end
   end

   // Read data register; holds its value across rejected and aborted accesses.
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         bus.RDATA <= '0;
      end else if (w_capture) begin
         bus.RDATA <= CDD_IN;
      end
   end

endmodule
